dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the execute stage's load/store port: the memory-side end of the `ldst_*` request interface. It accepts one request per cycle and absorbs stores into a small posted-write buffer. Loads are answered after a programmable number of wait states, with back-pressure on a single stall line. It replaces the zero-latency `mem_data` array with a realistic slave so that execute-stage stall handling can be exercised.

## Interface
- `ADDR_W`, 10, word-address width; array depth is 2**ADDR_W words.
- `DATA_W`, 32, data word width.
- `LATENCY`, 2, load wait states (0..15).
- `WBUF_DEPTH`, 4, posted-write buffer entries (power of two, ≥2).

- `clk` in 1: single clock, all state on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_i` in 1: request valid.
- `write_i` in 1: 1 = store, 0 = load; qualified by `req_i`.
- `addr_i` in ADDR_W: word address.
- `data_i` in DATA_W: store data.
- `stall_o` out 1: request not accepted or load in progress; requester holds `req_i`/`write_i`/`addr_i`/`data_i` stable.
- `v_o` out 1: one-cycle pulse, load data valid.
- `data_o` out DATA_W: load data, valid when `v_o`=1.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - DRAIN: load waits for the buffer to empty.
  - WAIT: counts LATENCY cycles.
  - RESP: `v_o`=1.
- Store: accepted in IDLE when `req_i`&`write_i` and count<WBUF_DEPTH. Address and data are pushed to the FIFO tail. `stall_o`=0 that cycle.
- Store with a full buffer: `stall_o`=1 and nothing is pushed. Fullness uses the count before any same-cycle drain.
- Drain: the array has one write port. The FIFO head is written to the array in any cycle where count>0 and no store is accepted. This includes DRAIN, WAIT and RESP.
- Load accept, in IDLE with `req_i`&~`write_i`:
  - `stall_o`=1 combinationally.
  - The address is latched.
  - count_next is the post-drain count. Next state is WAIT if count_next==0, else DRAIN.
  - With LATENCY=0, the WAIT target is replaced by RESP.
- DRAIN: `stall_o`=1. Move to WAIT (or RESP if LATENCY=0) in the cycle where count_next==0.
- WAIT:
  - `stall_o`=1; a down-counter is loaded with LATENCY−1.
  - Move to RESP when the counter reaches 0.
  - On that transition, `data_o` is registered from the array at the latched address.
- RESP:
  - `v_o`=1 and `stall_o`=0.
  - `req_i` is ignored because it is the completing load.
  - Next state is always IDLE.
- `stall_o` = (IDLE & `req_i` & ~`write_i`) | (IDLE & `req_i` & `write_i` & full) | DRAIN | WAIT.
- Reset values: state=IDLE, FIFO pointers and count=0, counter=0, `v_o`=0, `data_o`=0, `stall_o`=0 (with `req_i`=0). Array contents are not reset.
- Reset mid-operation: any in-flight load is aborted and no `v_o` is issued. Buffered stores are discarded.
- Address wrap-around: FIFO pointers are mod WBUF_DEPTH. Array addresses are ADDR_W bits, so no out-of-range case exists.

## Timing
- Load accepted at cycle T with an empty buffer: WAIT occupies T+1..T+LATENCY, and `v_o`=1 at T+LATENCY+1.
- Each pending entry remaining after the T drain adds one DRAIN cycle (no-forwarding build).
- Store: zero-cycle acceptance. It reaches the array no earlier than the next non-store cycle.
- The earliest new request after RESP is at RESP+1.

## Configuration
- `DMEM_STORE_FWD_EN` defined:
  - Loads never enter DRAIN; accept goes straight to WAIT/RESP.
  - On the transition into RESP, `data_o` takes the youngest FIFO entry matching the latched address, else the array.
  - Draining continues in the background.
- Undefined: there is no FIFO address compare. Loads always wait in DRAIN until the buffer is empty.

## Test plan
- Reset: hold `reset`=1 for 2 cycles, then release with `req_i`=0 → `stall_o`=0, `v_o`=0, `data_o`=0.
- Store then load, both builds:
  - Store 0x000000AA @5 at T, load @5 at T+1.
  - Expected: `stall_o`=1 on T+1..T+3, `v_o`=1 with `data_o`=0x000000AA at T+4.
- Buffer full: stores @0..@4 on consecutive cycles T..T+4.
  - The fifth store sees `stall_o`=1 at T+4, the head drains, and the store is accepted at T+5.
  - Loads @0..@4 afterwards return the five values.
- Forwarding:
  - Stores 1, 2, 3 @7 at T..T+2, then load @7 at T+3.
  - `DMEM_STORE_FWD_EN` defined: `v_o`=1, `data_o`=3 at T+6.
  - Undefined: DRAIN on T+4..T+5, `v_o`=1, `data_o`=3 at T+8.
- LATENCY=0: load of an unbuffered address at T → `v_o`=1 at T+1. `stall_o`=1 only in cycle T.
- Reset mid-WAIT:
  - Preload @9=0x11, store 0x22 @9, then load @9.
  - Assert `reset` during WAIT → no `v_o` pulse and state IDLE.
  - A subsequent load @9 returns 0x11 if the store had not drained; this is checked via the buffer count before reset.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory slave for the ldst_* port: posted-write buffer plus load wait states and stall.
// Build option DMEM_STORE_FWD_EN: loads forward from the write buffer instead of waiting for it.
module dmem_responder #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              stall_o,
    output logic              v_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int unsigned PtrW     = $clog2(WBUF_DEPTH);
    localparam int unsigned CntW     = PtrW + 1;
    localparam int unsigned MemDepth = 2 ** ADDR_W;
    localparam logic [3:0]  WaitInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StDrain, StWait, StResp} state_e;

    localparam state_e LoadGo = (LATENCY == 0) ? StResp : StWait;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mem_q [MemDepth];

    logic              full;
    logic              store_acc;
    logic              drain;
    logic              resp_load;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] arr_rdata;
    logic [DATA_W-1:0] ld_rdata;

    // Write buffer bookkeeping; the array write port drains whenever no store is taken.
    always_comb begin
        full      = (cnt_q == CntW'(WBUF_DEPTH));
        store_acc = (state_q == StIdle) && req_i && write_i && !full;
        drain     = (cnt_q != '0) && !store_acc;
        head_addr = wb_addr_q[rd_ptr_q];
        head_data = wb_data_q[rd_ptr_q];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (store_acc) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            cnt_d    = cnt_q + CntW'(1);
        end else if (drain) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            cnt_d    = cnt_q - CntW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ld_addr_d = ld_addr_q;
        stall_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i && !write_i) begin
                    stall_o   = 1'b1;
                    ld_addr_d = addr_i;
`ifdef DMEM_STORE_FWD_EN
                    state_d   = LoadGo;
`else
                    state_d   = (cnt_d == '0) ? LoadGo : StDrain;
`endif
                end else if (req_i && write_i && full) begin
                    stall_o = 1'b1;
                end
            end
            StDrain: begin
                stall_o = 1'b1;
                if (cnt_d == '0) begin
                    state_d = LoadGo;
                end
            end
            StWait: begin
                stall_o = 1'b1;
                if (wait_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (state_d == StWait && state_q != StWait) begin
            wait_d = WaitInit;
        end
        resp_load = (state_d == StResp) && (state_q != StResp);
    end

    // Before the address is latched (zero-latency accept) the live request address is used.
    assign rd_addr = (state_q == StIdle) ? addr_i : ld_addr_q;

`ifdef DMEM_STORE_FWD_EN
    logic [PtrW-1:0] fwd_idx;

    always_comb begin
        arr_rdata = mem_q[rd_addr];
        if (drain && head_addr == rd_addr) begin
            arr_rdata = head_data;
        end
        ld_rdata = arr_rdata;
        fwd_idx  = '0;
        // Scan oldest to youngest so the youngest matching entry wins.
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            fwd_idx = rd_ptr_q + PtrW'(i);
            if (i < int'(cnt_q) && wb_addr_q[fwd_idx] == rd_addr) begin
                ld_rdata = wb_data_q[fwd_idx];
            end
        end
    end
`else
    always_comb begin
        arr_rdata = mem_q[rd_addr];
        // The last entry may drain on the same edge the read is registered.
        if (drain && head_addr == rd_addr) begin
            arr_rdata = head_data;
        end
        ld_rdata = arr_rdata;
    end
`endif

    assign data_d = resp_load ? ld_rdata : data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            ld_addr_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            ld_addr_q <= ld_addr_d;
            data_q    <= data_d;
        end
    end

    // Storage is not reset; writes are suppressed while reset discards the buffer.
    always_ff @(posedge clk) begin
        if (!reset && store_acc) begin
            wb_addr_q[wr_ptr_q] <= addr_i;
            wb_data_q[wr_ptr_q] <= data_i;
        end
        if (!reset && drain) begin
            mem_q[head_addr] <= head_data;
        end
    end

    assign v_o    = (state_q == StResp);
    assign data_o = data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder against a queue/array reference model, plus directed cases.
module tb_dmem_responder;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int WB  = 4;
`ifdef DMEM_STORE_FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, req, wr, stall, v;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;

    logic          reset0, req0, wr0, stall0, v0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0, rdata0;
    bit            done0 = 1'b0;

    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .WBUF_DEPTH(WB)) u_dut (
        .clk(clk), .reset(reset), .req_i(req), .write_i(wr), .addr_i(addr), .data_i(wdata),
        .stall_o(stall), .v_o(v), .data_o(rdata)
    );

    dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(0), .WBUF_DEPTH(WB)) u_dut0 (
        .clk(clk), .reset(reset0), .req_i(req0), .write_i(wr0), .addr_i(addr0), .data_i(wdata0),
        .stall_o(stall0), .v_o(v0), .data_o(rdata0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: committed array, pending store queue, and an outstanding-load countdown.
    logic [DW-1:0] m_mem   [2**AW];
    bit            m_known [2**AW];
    logic [AW-1:0] q_a [$];
    logic [DW-1:0] q_d [$];
    bit            m_live = 1'b0;
    bit            m_busy = 1'b0;
    int            m_left = 0;
    logic [DW-1:0] m_exp;
    bit            m_exp_known;
    bit            m_stall = 1'b1;
    bit            u_idle, u_resp, u_st;
    bit            c_idle, c_resp;

    function automatic void lookup(input logic [AW-1:0] a, output logic [DW-1:0] d, output bit k);
        d = m_mem[a];
        k = m_known[a];
        foreach (q_a[i]) begin
            if (q_a[i] == a) begin
                d = q_d[i];
                k = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q_a.delete();
            q_d.delete();
            m_busy = 1'b0;
            m_live = 1'b1;
        end else if (m_live) begin
            u_idle = !m_busy;
            u_resp = m_busy && m_left == 0;
            u_st   = u_idle && req && wr && q_a.size() < WB;
            if (u_idle && req && !wr) lookup(addr, m_exp, m_exp_known);
            if (u_st) begin
                q_a.push_back(addr);
                q_d.push_back(wdata);
            end else if (q_a.size() > 0) begin
                m_mem[q_a[0]]   = q_d[0];
                m_known[q_a[0]] = 1'b1;
                void'(q_a.pop_front());
                void'(q_d.pop_front());
            end
            if (u_idle && req && !wr) begin
                m_busy = 1'b1;
                m_left = (Fwd ? 0 : q_a.size()) + LAT;
            end else if (u_resp) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_left--;
            end
        end
    end

    always @(negedge clk) begin
        if (reset || !m_live) begin
            m_stall = 1'b1;
        end else begin
            c_idle  = !m_busy;
            c_resp  = m_busy && m_left == 0;
            m_stall = c_idle ? (req && (!wr || q_a.size() == WB)) : !c_resp;
            chk("stall_o", stall, m_stall);
            chk("v_o", v, c_resp);
            if (c_resp && m_exp_known) chk("data_o", rdata, m_exp);
        end
    end

    task automatic cyc(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        req = r; wr = w; addr = a; wdata = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0);
    endtask

    task automatic store_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        cyc(1'b1, 1'b1, a, d);
        while (stall === 1'b1 && n < 64) begin
            cyc(1'b1, 1'b1, a, d);
            n++;
        end
        if (n == 64) chk("store timeout", 32'(n), 32'd0);
    endtask

    task automatic load_op(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        lat = 0;
        cyc(1'b1, 1'b0, a, '0);
        while (v !== 1'b1 && lat < 64) begin
            cyc(1'b1, 1'b0, a, '0);
            lat++;
        end
        d = rdata;
    endtask

    logic [AW-1:0] pool [16];
    logic [DW-1:0] d;
    int            lat;

    initial begin
        reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 16; i++) pool[i] = (i < 8) ? AW'(i) : AW'(1008 + i);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset stall_o", stall, 1'b0);
        chk("reset v_o", v, 1'b0);
        chk("reset data_o", rdata, 32'd0);

        for (int i = 0; i < 16; i++) store_op(pool[i], $urandom);
        store_op(10'd9, 32'h0);
        idle(6);

        // Store then load of the same word.
        cyc(1'b1, 1'b1, 10'd5, 32'hAA);
        chk("st5 stall", stall, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1, 1'b0, 10'd5, '0);
            chk("ld5 stall", stall, 1'b1);
            chk("ld5 no v", v, 1'b0);
        end
        cyc(1'b1, 1'b0, 10'd5, '0);
        chk("ld5 v", v, 1'b1);
        chk("ld5 data", rdata, 32'hAA);
        chk("ld5 resp stall", stall, 1'b0);
        idle(6);

        // Buffer full: fifth back-to-back store stalls once.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, AW'(i), 32'h100 + 32'(i));
            chk("fill stall", stall, 1'b0);
        end
        cyc(1'b1, 1'b1, 10'd4, 32'h104);
        chk("full stall", stall, 1'b1);
        cyc(1'b1, 1'b1, 10'd4, 32'h104);
        chk("full accept", stall, 1'b0);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            load_op(AW'(i), d, lat);
            chk("full readback", d, 32'h100 + 32'(i));
        end
        idle(6);

        // Three stores to one word, then a load of it.
        for (int k = 1; k <= 3; k++) cyc(1'b1, 1'b1, 10'd7, 32'(k));
        load_op(10'd7, d, lat);
        chk("fwd data", d, 32'd3);
        chk("fwd latency", 32'(lat), Fwd ? 32'd3 : 32'd5);
        idle(6);

        // Reset while the load sits in WAIT; the store already drained.
        store_op(10'd9, 32'h11);
        idle(4);
        cyc(1'b1, 1'b1, 10'd9, 32'h22);
        cyc(1'b1, 1'b0, 10'd9, '0);
        chk("rst-ld stall", stall, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("wait stall", stall, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("post-reset v", v, 1'b0);
            chk("post-reset stall", stall, 1'b0);
            cyc(1'b0, 1'b0, '0, '0);
        end
        load_op(10'd9, d, lat);
        chk("post-reset load", d, 32'h22);
        idle(2);

        // Random traffic; a request is replaced only once it has been consumed.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                req   = 1'b0;
            end else begin
                reset = 1'b0;
                if (!req || !m_stall) begin
                    req   = ($urandom_range(0, 3) != 0);
                    wr    = ($urandom_range(0, 2) != 0);
                    addr  = pool[$urandom_range(0, 15)];
                    wdata = $urandom;
                end
            end
        end
        @(posedge clk);
        #1 reset = 1'b0; req = 1'b0;
        idle(8);

        wait (done0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Zero-latency instance: directed timing cases.
    initial begin
        reset0 = 1'b1; req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        repeat (2) @(posedge clk);
        #1 reset0 = 1'b0;
        @(posedge clk);
        #1 req0 = 1'b1; wr0 = 1'b1; addr0 = 10'd2; wdata0 = 32'h5A;
        @(posedge clk);
        #1 req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 req0 = 1'b1; wr0 = 1'b0; addr0 = 10'd2;
        @(negedge clk);
        chk("lat0 accept stall", stall0, 1'b1);
        chk("lat0 accept v", v0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("lat0 v", v0, 1'b1);
        chk("lat0 data", rdata0, 32'h5A);
        chk("lat0 resp stall", stall0, 1'b0);
        @(posedge clk);
        #1 req0 = 1'b1; wr0 = 1'b1; addr0 = 10'd3; wdata0 = 32'h77;
        @(negedge clk);
        chk("lat0 st stall", stall0, 1'b0);
        @(posedge clk);
        #1 wr0 = 1'b0;
        @(negedge clk);
        chk("lat0 ld3 stall", stall0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("lat0 ld3 v", v0, 1'b1);
        chk("lat0 ld3 data", rdata0, 32'h77);
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        chk("lat0 idle v", v0, 1'b0);
        chk("lat0 idle stall", stall0, 1'b0);
        done0 = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
